// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request/result bundle for the iterative multiply/divide unit.
//   start/op/x/y  : operation request (op 00=MULT 01=MULTU 10=DIV 11=DIVU)
//   hi_we/lo_we   : MTHI / MTLO write enables, data on wdata
//   busy/done     : operation in progress / one-cycle completion pulse
//   hi/lo         : architectural HI/LO registers, readable at any time
// master drives requests (pipeline side), slave is the unit itself.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, x, y, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, x, y, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears HI/LO, aborts any operation)
//   bus  : mdu_hilo_if.slave -- start/op/x/y request, hi_we/lo_we/wdata
//          MTHI/MTLO writes, busy/done status, hi/lo register outputs.
// An accepted request is captured, converted to magnitudes, iterated for
// WIDTH cycles (shift-add or restoring shift-subtract), sign-corrected and
// written to HI/LO. busy covers the WIDTH iteration cycles plus the fix-up.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_hilo_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_d;

    logic             vld_p0;
    logic [1:0]       op_p0;
    logic [WIDTH-1:0] x_p0;
    logic [WIDTH-1:0] y_p0;

    logic [WIDTH-1:0] acc_hi_p1;
    logic [WIDTH-1:0] acc_lo_p1;
    logic [WIDTH-1:0] opnd_p1;
    logic [CW-1:0]    cnt_p1;
    logic             is_div_p1;
    logic             neg_lo_p1;
    logic             neg_hi_p1;
    logic             dz_p1;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             write_ok;
    logic             in_signed;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        // The most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] set_sign(input logic [WIDTH-1:0] m,
                                                  input logic neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(m);
        return neg ? $unsigned(-s) : m;
    endfunction

    function automatic logic [2*WIDTH-1:0] set_sign_wide(input logic [2*WIDTH-1:0] m,
                                                         input logic neg);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(m);
        return neg ? $unsigned(-s) : m;
    endfunction

    // A request slot exists only when nothing is captured or iterating.
    assign accept   = bus.start && (state == IDLE) && !vld_p0;
    assign write_ok = (state == IDLE) && !vld_p0 && !bus.start;

    // ---- stage p0: capture raw request ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
        if (accept) begin
            op_p0 <= bus.op;
            x_p0  <= bus.x;
            y_p0  <= bus.y;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (vld_p0) state_d = CALC;
            CALC:    if (cnt_p1 == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            busy_q <= (state_d != IDLE);
            done_q <= (state == FIX);
        end
    end

    always_comb begin
        in_signed = !op_p0[0];
        x_mag     = in_signed ? mag(x_p0) : x_p0;
        y_mag     = in_signed ? mag(y_p0) : y_p0;
        // Multiply: add multiplicand into the upper half when the multiplier
        // LSB is set, then shift the whole {acc_hi,acc_lo} right by one.
        mul_sum   = {1'b0, acc_hi_p1} + {1'b0, (acc_lo_p1[0] ? opnd_p1 : '0)};
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract when it fits. A fitting difference is always below the
        // divisor, so the low WIDTH bits of the subtraction are exact.
        div_shift = {acc_hi_p1, acc_lo_p1[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_p1});
        div_sub   = div_shift[WIDTH-1:0] - opnd_p1;
    end

    // ---- stage p1: magnitude setup and WIDTH iteration steps ----
    always_ff @(posedge clk) begin
        if (state == IDLE && vld_p0) begin
            acc_hi_p1 <= '0;
            acc_lo_p1 <= op_p0[1] ? x_mag : y_mag;
            opnd_p1   <= op_p0[1] ? y_mag : x_mag;
            cnt_p1    <= '0;
            is_div_p1 <= op_p0[1];
            neg_lo_p1 <= in_signed && (x_p0[WIDTH-1] ^ y_p0[WIDTH-1]);
            neg_hi_p1 <= in_signed && x_p0[WIDTH-1];
            dz_p1     <= op_p0[1] && (y_p0 == '0);
        end else if (state == CALC) begin
            cnt_p1 <= cnt_p1 + 1'b1;
            if (is_div_p1) begin
                acc_hi_p1 <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                acc_lo_p1 <= {acc_lo_p1[WIDTH-2:0], div_ge};
            end else begin
                acc_hi_p1 <= mul_sum[WIDTH:1];
                acc_lo_p1 <= {mul_sum[0], acc_lo_p1[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod   = set_sign_wide({acc_hi_p1, acc_lo_p1}, neg_lo_p1);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_p1) begin
            // Divide by zero bypasses sign correction entirely.
            res_hi = dz_p1 ? x_p0 : set_sign(acc_hi_p1, neg_hi_p1);
            res_lo = dz_p1 ? '1   : set_sign(acc_lo_p1, neg_lo_p1);
        end
    end

    // ---- stage p2: sign fix-up and HI/LO write ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (write_ok) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed-vector bench for mdu_hilo (WIDTH=32).
module tb_mdu_hilo;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mdu_hilo_if #(.WIDTH(32)) bus();

    mdu_hilo #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; the request is sampled at the next edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = a;
        bus.y     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Observes cycles after the start edge. inj_k > 0 injects a second start
    // plus an MTHI write in that cycle.
    task automatic track(input int max_cyc, input bit stop_on_done, input int inj_k,
                         output int lat, output int bcnt, output int npulse,
                         output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        lat = 0; bcnt = 0; npulse = 0; mid_hi = '0; mid_lo = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            #1;
            if (k == inj_k) begin
                bus.start = 1'b1; bus.op = MULTU; bus.x = 32'd2; bus.y = 32'd2;
                bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
            end else if (k == inj_k + 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            if (k == 20) begin
                mid_hi = bus.hi;
                mid_lo = bus.lo;
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                npulse++;
                if (lat == 0) lat = k;
                if (stop_on_done) break;
            end
        end
    endtask

    task automatic write_hilo(input bit hwe, input bit lwe, input logic [31:0] d);
        bus.hi_we = hwe; bus.lo_we = lwe; bus.wdata = d;
        @(posedge clk);
        #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int lat, bcnt, np;
        logic [31:0] mh, ml;
        issue(op, a, b);
        track(60, 1'b1, 0, lat, bcnt, np, mh, ml);
        check({tag, "_lat"}, lat, 32'd34);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bcnt, np;
        logic [31:0] mh, ml;
        bus.start = 1'b0; bus.op = 2'b00; bus.x = '0; bus.y = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);

        // 1: MULTU max*max with exact latency and busy length
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        track(60, 1'b1, 0, lat, bcnt, np, mh, ml);
        check("t1_lat", lat, 32'd34);
        check("t1_busy_cycles", bcnt, 32'd33);
        check("t1_hi", bus.hi, 32'hFFFFFFFE);
        check("t1_lo", bus.lo, 32'h00000001);
        @(posedge clk);
        #1 check("t1_done_fall", {31'b0, bus.done}, 32'h0);

        // 2: signed multiply and divide
        run_op("t2_mult", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("t2_div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // 3: divide by zero and overflow wrap
        run_op("t3_dz", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run_op("t3_dzs", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("t3_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // 4: start and MTHI while busy are ignored; HI/LO stable during busy
        issue(DIVU, 32'd10, 32'd3);
        track(45, 1'b0, 5, lat, bcnt, np, mh, ml);
        check("t4_mid_hi", mh, 32'h0);
        check("t4_mid_lo", ml, 32'h80000000);
        check("t4_lat", lat, 32'd34);
        check("t4_pulses", np, 32'd1);
        check("t4_hi", bus.hi, 32'd1);
        check("t4_lo", bus.lo, 32'd3);

        // 5: reset aborts an operation; MTLO afterwards
        write_hilo(1'b1, 1'b0, 32'h11);
        write_hilo(1'b0, 1'b1, 32'h22);
        check("t5_mthi", bus.hi, 32'h11);
        check("t5_mtlo", bus.lo, 32'h22);
        issue(MULTU, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_rst_hi", bus.hi, 32'h0);
        check("t5_rst_lo", bus.lo, 32'h0);
        check("t5_rst_busy", {31'b0, bus.busy}, 32'h0);
        track(40, 1'b0, 0, lat, bcnt, np, mh, ml);
        check("t5_no_done", np, 32'd0);
        write_hilo(1'b0, 1'b1, 32'h5);
        check("t5_mtlo_idle", bus.lo, 32'h5);
        check("t5_hi_kept", bus.hi, 32'h0);

        // both enables load the same data; write alongside start is dropped
        write_hilo(1'b1, 1'b1, 32'hA5);
        check("both_hi", bus.hi, 32'hA5);
        check("both_lo", bus.lo, 32'hA5);
        bus.lo_we = 1'b1; bus.wdata = 32'h77;
        issue(MULTU, 32'd3, 32'd3);
        bus.lo_we = 1'b0;
        check("start_wins_lo", bus.lo, 32'hA5);

        // 6: back-to-back start in the done cycle
        track(60, 1'b1, 0, lat, bcnt, np, mh, ml);
        check("t6a_lat", lat, 32'd34);
        check("t6a_hi", bus.hi, 32'h0);
        check("t6a_lo", bus.lo, 32'd9);
        run_op("t6b", DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Iterative multiply/divide unit that executes MULT/MULTU/DIV/DIVU and owns the HI/LO architectural registers. The combinational datapath computes single-word results only; this block is the consumer side that latches 64-bit products and quotient/remainder pairs into HI/LO. It serves MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO reads. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request pulse; accepted only when busy=0.
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
x  input  WIDTH  rs operand (dividend / multiplicand); sampled with start.
y  input  WIDTH  rt operand (divisor / multiplier); sampled with start.
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  MTHI/MTLO data.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
hi  output  WIDTH  HI register (MULT: upper product; DIV: remainder).
lo  output  WIDTH  LO register (MULT: lower product; DIV: quotient).

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. On rst: hi=0, lo=0, busy=0, done=0, FSM=IDLE. Any operation in flight is aborted and produces no HI/LO update.
- FSM states:
  - IDLE: start=1 at an edge latches op/x/y, converts signed operands to magnitudes and records the result signs, then goes to CALC with counter=0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Moves to FIX after WIDTH steps (counter WIDTH-1).
  - FIX: applies sign correction and writes hi/lo at the edge leaving FIX. Goes to IDLE with done=1 for that one cycle.
- Latency: with start sampled at edge N, busy=1 for cycles N+1 .. N+WIDTH+1 (WIDTH CALC + 1 FIX = 33 cycles). From edge N+WIDTH+2: done=1, busy=0, new hi/lo visible. done falls after one cycle.
- A back-to-back start is legal in the done cycle.
- Registered outputs: busy and done are registered. hi and lo are the register outputs themselves; no read latency.
- Signed multiply: 64-bit two's-complement product, {hi,lo}.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (DIV or DIVU, y=0): lo=all-ones, hi=x unmodified. Sign correction is skipped. Latency is unchanged.
- Start while busy=1: ignored; no queueing.
- MTHI/MTLO:
  - hi_we/lo_we when busy=0 and start=0: hi/lo=wdata at the next edge.
  - Writes while busy=1 are ignored.
  - If start and a write occur in the same cycle, start wins and the write is dropped.
  - If hi_we and lo_we are both set, both registers load wdata.
- Stability: hi/lo hold their values throughout busy. Reads during busy return the previous values.
- done is never asserted by MTHI/MTLO, only by operation completion.

Test Plan:
1. MULTU: x=0xFFFFFFFF, y=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start edge; busy high exactly 33 cycles.
2. MULT: x=0xFFFFFFFD (-3), y=7. Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV: x=0xFFFFFFF9 (-7), y=2. Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU: x=100, y=0. Required: lo=0xFFFFFFFF, hi=0x00000064. DIV: x=0x80000000, y=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
4. Busy guards: start DIVU 10/3, then pulse start (MULTU 2*2) and hi_we (wdata=0xDEAD) mid-operation. Required: final hi=1, lo=3; the second start and the write have no effect; a single done pulse.
5. Reset mid-operation: hi=0x11, lo=0x22 via MTHI/MTLO, start MULTU 5*5, assert rst at cycle 10. Required: hi=lo=0, busy=0, done never pulses. Then MTLO wdata=0x5 while idle gives lo=0x5 at the next edge.
6. Back-to-back: issue a new start (DIVU 9/4) in the done cycle of a MULTU 3*3. Required: first result hi=0, lo=9; second result hi=1, lo=2, 34 cycles after its start edge.
